// File: rtl/mul_err_pkg.sv
// Shared definitions for the approximate-multiplier error sweep: FSM encoding,
// parameter defaults and product/counter width helpers.
package mul_err_pkg;

    localparam int unsigned WDef    = 8;
    localparam int unsigned LatDef  = 0;
    localparam int unsigned AccWDef = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } sweep_state_e;

    // Product width
    function automatic int unsigned pw_of(int unsigned w);
        return 2 * w;
    endfunction

    // Sample/error counter width: holds 2^(2W) exactly
    function automatic int unsigned cw_of(int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/op_sweep_gen.sv
// Operand pair counter: b is the inner index, a advances when b wraps.
module op_sweep_gen #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] op_a_o,
    output logic [W-1:0] op_b_o,
    output logic         last_o
);

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (clr_i) begin
            a_d = '0;
            b_d = '0;
        end else if (en_i) begin
            b_d = b_q + W'(1);
            if (&b_q) begin
                a_d = a_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign op_a_o = a_q;
    assign op_b_o = b_q;
    assign last_o = (&a_q) & (&b_q);

endmodule

// File: rtl/mul_err_sweep.sv
// Exhaustive sweep of a W x W multiplier-under-test: issues every operand pair, aligns the
// returned product with its operands and accumulates error-distance statistics on chip.
module mul_err_sweep
    import mul_err_pkg::*;
#(
    parameter int unsigned W     = WDef,
    parameter int unsigned LAT   = LatDef,
    parameter int unsigned ACC_W = AccWDef
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [W-1:0]          op_a,
    output logic [W-1:0]          op_b,
    input  logic [pw_of(W)-1:0]   prod_in,
    output logic [cw_of(W)-1:0]   sample_cnt,
    output logic [cw_of(W)-1:0]   err_cnt,
    output logic [ACC_W-1:0]      sum_ed,
    output logic [pw_of(W)-1:0]   max_ed,
    output logic [W-1:0]          max_a,
    output logic [W-1:0]          max_b
);

    localparam int unsigned PW = pw_of(W);
    localparam int unsigned CW = cw_of(W);
    localparam int unsigned TW = 2 * W + 2;

    sweep_state_e state_q, state_d;
    logic         start_acc;
    logic         issue_vld;
    logic         gen_last;

    logic          cmp_vld_q, cmp_last_q;
    logic [W-1:0]  cmp_a_q, cmp_b_q;
    logic [PW-1:0] cmp_exact_q, cmp_prod_q;
    logic [PW-1:0] ed;

    logic [CW-1:0]    sample_q, err_q;
    logic [ACC_W-1:0] sum_q;
    logic [PW-1:0]    max_ed_q;
    logic [W-1:0]     max_a_q, max_b_q;

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (gen_last) state_d = StDrain;
            end
            StDrain: begin
                // The last pair is in the compare stage; it accumulates on this edge
                if (cmp_vld_q && cmp_last_q) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    assign issue_vld = (state_q == StRun);
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = (state_q == StDone);

    op_sweep_gen #(
        .W (W)
    ) u_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (issue_vld && !gen_last),
        .clr_i  (start_acc),
        .op_a_o (op_a),
        .op_b_o (op_b),
        .last_o (gen_last)
    );

    // Issue-side delay line so operands meet their product LAT cycles later
    logic [TW-1:0] tap_in, tap_out;
    assign tap_in = {issue_vld, gen_last, op_a, op_b};

    if (LAT == 0) begin : g_comb
        assign tap_out = tap_in;
    end else begin : g_line
        logic [TW-1:0] line_q [LAT];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < LAT; i++) line_q[i] <= '0;
            end else begin
                line_q[0] <= tap_in;
                for (int unsigned i = 1; i < LAT; i++) line_q[i] <= line_q[i-1];
            end
        end
        assign tap_out = line_q[LAT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_vld_q   <= 1'b0;
            cmp_last_q  <= 1'b0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            cmp_exact_q <= '0;
            cmp_prod_q  <= '0;
        end else begin
            cmp_vld_q   <= tap_out[TW-1];
            cmp_last_q  <= tap_out[TW-2];
            cmp_a_q     <= tap_out[2*W-1:W];
            cmp_b_q     <= tap_out[W-1:0];
            cmp_exact_q <= PW'(tap_out[2*W-1:W]) * PW'(tap_out[W-1:0]);
            cmp_prod_q  <= prod_in;
        end
    end

    assign ed = (cmp_prod_q >= cmp_exact_q) ? (cmp_prod_q - cmp_exact_q)
                                            : (cmp_exact_q - cmp_prod_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            err_q    <= '0;
            sum_q    <= '0;
            max_ed_q <= '0;
            max_a_q  <= '0;
            max_b_q  <= '0;
        end else if (start_acc) begin
            sample_q <= '0;
            err_q    <= '0;
            sum_q    <= '0;
            max_ed_q <= '0;
            max_a_q  <= '0;
            max_b_q  <= '0;
        end else if (cmp_vld_q) begin
            sample_q <= sample_q + CW'(1);
            if (ed != '0) err_q <= err_q + CW'(1);
            sum_q <= sum_q + ACC_W'(ed);
            // Strictly greater: ties keep the earliest pair
            if (ed > max_ed_q) begin
                max_ed_q <= ed;
                max_a_q  <= cmp_a_q;
                max_b_q  <= cmp_b_q;
            end
        end
    end

    assign sample_cnt = sample_q;
    assign err_cnt    = err_q;
    assign sum_ed     = sum_q;
    assign max_ed     = max_ed_q;
    assign max_a      = max_a_q;
    assign max_b      = max_b_q;

endmodule

// File: tb/tb_mul_err_sweep.sv
// Scoreboard bench: two sweep engines (LAT 0 and LAT 3, W=4) share a product table model;
// expected final statistics are queued at start and checked when done rises.
module tb_mul_err_sweep;

    localparam int unsigned W    = 4;
    localparam int unsigned N    = 1 << (2 * W);
    localparam int unsigned AccW = 16;

    typedef struct {
        int sample;
        int err;
        int sum;
        int maxed;
        int maxa;
        int maxb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0] prod_tab [N];
    exp_t q0[$];
    exp_t q3[$];

    logic       busy0, done0, busy3, done3;
    logic [3:0] op_a0, op_b0, op_a3, op_b3, ma0, mb0, ma3, mb3;
    logic [7:0] prod0, prod3, med0, med3;
    logic [8:0] sc0, ec0, sc3, ec3;
    logic [15:0] sum0, sum3;
    logic [7:0] d1, d2, d3;

    assign prod0 = prod_tab[{op_a0, op_b0}];
    // Registered multiplier model with three cycles of latency
    always @(posedge clk) begin
        d1 <= {op_a3, op_b3};
        d2 <= d1;
        d3 <= d2;
    end
    assign prod3 = prod_tab[d3];

    mul_err_sweep #(.W(W), .LAT(0), .ACC_W(AccW)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0),
        .op_a(op_a0), .op_b(op_b0), .prod_in(prod0), .sample_cnt(sc0), .err_cnt(ec0),
        .sum_ed(sum0), .max_ed(med0), .max_a(ma0), .max_b(mb0)
    );

    mul_err_sweep #(.W(W), .LAT(3), .ACC_W(AccW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy3), .done(done3),
        .op_a(op_a3), .op_b(op_b3), .prod_in(prod3), .sample_cnt(sc3), .err_cnt(ec3),
        .sum_ed(sum3), .max_ed(med3), .max_a(ma3), .max_b(mb3)
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: walk the table in sweep order and derive the statistics directly
    function automatic exp_t model_stats();
        exp_t e;
        int ed;
        e = '{default: 0};
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                int p;
                p  = int'(prod_tab[a * (1 << W) + b]);
                ed = (p > a * b) ? p - a * b : a * b - p;
                e.sample++;
                if (ed != 0) e.err++;
                e.sum += ed;
                if (ed > e.maxed) begin
                    e.maxed = ed;
                    e.maxa  = a;
                    e.maxb  = b;
                end
            end
        end
        return e;
    endfunction

    task automatic build_table(input int mode);
        for (int i = 0; i < int'(N); i++) begin
            int ex;
            ex = (i >> W) * (i & ((1 << W) - 1));
            case (mode)
                0: prod_tab[i] = 8'(ex);
                1: prod_tab[i] = 8'(ex) & 8'hFE;
                2: prod_tab[i] = (i == int'(N) - 1) ? 8'hFF : 8'(ex);
                default: prod_tab[i] = ($urandom_range(3) == 0) ? 8'($urandom) : 8'(ex);
            endcase
        end
    endtask

    // Final-statistics monitors: one per engine
    int   last0 = -1, last3 = -1;
    logic pd0 = 1'b0, pd3 = 1'b0;

    task automatic check_final(input string tag, input exp_t e, input int lat_obs,
                               input int lat_req, input logic bz, input logic [8:0] sc,
                               input logic [8:0] ec, input logic [15:0] sm,
                               input logic [7:0] md, input logic [3:0] ma, input logic [3:0] mb);
        chk({tag, " done_latency"}, lat_obs, lat_req);
        chk({tag, " busy_at_done"}, bz, 0);
        chk({tag, " sample_cnt"}, sc, e.sample);
        chk({tag, " err_cnt"}, ec, e.err);
        chk({tag, " sum_ed"}, sm, e.sum);
        chk({tag, " max_ed"}, md, e.maxed);
        chk({tag, " max_a"}, ma, e.maxa);
        chk({tag, " max_b"}, mb, e.maxb);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            last0 = -1;
            pd0   = 1'b0;
        end else begin
            if (busy0 && op_a0 == 4'hF && op_b0 == 4'hF && last0 < 0) last0 = cyc;
            if (done0 && !pd0) begin
                if (q0.size() == 0) chk("lat0 unexpected_done", 1, 0);
                else check_final("lat0", q0.pop_front(), cyc - last0, 2, busy0, sc0, ec0,
                                 sum0, med0, ma0, mb0);
                last0 = -1;
            end
            pd0 = done0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q3.delete();
            last3 = -1;
            pd3   = 1'b0;
        end else begin
            if (busy3 && op_a3 == 4'hF && op_b3 == 4'hF && last3 < 0) last3 = cyc;
            if (done3 && !pd3) begin
                if (q3.size() == 0) chk("lat3 unexpected_done", 1, 0);
                else check_final("lat3", q3.pop_front(), cyc - last3, 5, busy3, sc3, ec3,
                                 sum3, med3, ma3, mb3);
                last3 = -1;
            end
            pd3 = done3;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, " lat0 outputs_zero"},
            {busy0, done0, op_a0, op_b0, sc0, ec0, sum0, med0, ma0, mb0}, 0);
        chk({tag, " lat3 outputs_zero"},
            {busy3, done3, op_a3, op_b3, sc3, ec3, sum3, med3, ma3, mb3}, 0);
    endtask

    // pert: 0 none, 1 extra start mid-sweep (ignored), 2 reset mid-sweep (aborts)
    task automatic run_sweep(input int mode, input int pert);
        exp_t e;
        bit   fin;
        build_table(mode);
        e = model_stats();
        q0.push_back(e);
        q3.push_back(e);
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #1;
        chk("start lat0 done_cleared", done0, 0);
        chk("start lat0 busy_set", busy0, 1);
        chk("start lat0 ops_zero", {op_a0, op_b0}, 0);
        chk("start lat0 sample_cleared", sc0, 0);
        chk("start lat3 busy_set", busy3, 1);
        chk("start lat3 err_cleared", {ec3, sum3, med3}, 0);
        start = 1'b0;
        if (pert != 0) begin
            repeat (100) @(posedge clk);
            if (pert == 1) begin
                #2 start = 1'b1;
                @(posedge clk);
                #2 start = 1'b0;
            end else begin
                #3 rst_n = 1'b0;
                #1 check_zero("async_reset");
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b1;
                @(posedge clk);
                #1 check_zero("after_reset");
                return;
            end
        end
        fin = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if (done0 && done3) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) chk("sweep_timeout", 0, 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        #1 rst_n = 1'b1;
        run_sweep(0, 0);
        run_sweep(1, 0);
        run_sweep(2, 0);
        run_sweep(3, 0);
        run_sweep(3, 0);
        run_sweep(3, 1);
        run_sweep(3, 2);
        run_sweep(0, 0);
        run_sweep(3, 0);
        chk("lat0 queue_empty", q0.size(), 0);
        chk("lat3 queue_empty", q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
